ram_access_arbiter: RTL
=======================

# ram_access_arbiter

Shares one single-port image-buffer RAM (WORD_SIZE × LENGTH_SIZE, combinational read when rd=1, write on clk edge when wr=1 and rd=0) between two requesters: the AXI-stream pixel loader (writer) and the CNN engine (reader). Round-robin arbitration, one access per two cycles, registered read data with a valid pulse. Sits between the stream-input logic, the convolution datapath and the buffer RAM; the RAM is instantiated beside it at the top, not inside it.

## Interface
- WORD_SIZE, 8, data word width.
- LENGTH_SIZE, 784, RAM depth in words (28×28 MNIST image); ADR_SIZE = $clog2(LENGTH_SIZE), derived, not overridable.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wrReq  in  1  write request; held high until wrGnt.
- wrAdr  in  ADR_SIZE  write address.
- wrData  in  WORD_SIZE  write data.
- wrGnt  out  1  one-cycle pulse: write accepted (performed or rejected).
- rdReq  in  1  read request; held high until rdGnt.
- rdAdr  in  ADR_SIZE  read address.
- rdGnt  out  1  one-cycle pulse: read accepted.
- rdData  out  WORD_SIZE  registered read data.
- rdValid  out  1  one-cycle pulse: rdData is new.
- adrErr  out  1  one-cycle pulse: granted address ≥ LENGTH_SIZE, no RAM access.
- ramRd  out  1  to RAM rd.
- ramWr  out  1  to RAM wr.
- ramAdr  out  ADR_SIZE  to RAM adr.
- ramDataIn  out  WORD_SIZE  to RAM dataIn.
- ramDataOut  in  WORD_SIZE  from RAM dataOut (high-Z when ramRd=0).

## Operation
- FSM states: IDLE, WRITE, READ. Reset → IDLE, lastGnt=READ (first contested grant goes to writer).
- IDLE: sample requests. Only one asserted → grant it. Both → grant the one not in lastGnt. Latch address (and wrData) into ramAdr/ramDataIn registers; go to WRITE or READ. Neither → stay.
- WRITE (one cycle): wrGnt=1; ramWr=1 unless latched address ≥ LENGTH_SIZE, then ramWr=0 and adrErr=1. lastGnt←WRITE; → IDLE.
- READ (one cycle): rdGnt=1; ramRd=1 unless address out of range (then ramRd=0, adrErr=1, rdData unchanged, no rdValid). On the exit edge rdData←ramDataOut; rdValid=1 during the following cycle. lastGnt←READ; → IDLE.
- ramRd and ramWr never high together; ramDataOut sampled only in READ with ramRd=1 (never captures Z).
- Requests that drop before grant are ignored; a request still high in IDLE after its own grant is a new access.

## Timing
- Reset values: wrGnt, rdGnt, rdValid, adrErr, ramRd, ramWr = 0; rdData, ramAdr, ramDataIn = 0.
- Grant/strobe outputs decode from state register only (no combinational path from req inputs).
- Write: req seen at edge k → WRITE in cycle k+1 (ramWr, wrGnt) → RAM written at edge k+2.
- Read: req seen at edge k → READ in cycle k+1 (ramRd, rdGnt) → rdData/rdValid in cycle k+2.
- Max throughput: one access per 2 cycles; both requesters held high alternate W,R,W,R.
- rst high at an edge while in WRITE: RAM still writes on that edge (RAM has no reset); FSM → IDLE, all strobes 0 next cycle. rst in READ: read discarded, no rdValid.
- Addresses compared against LENGTH_SIZE at full ADR_SIZE width, unsigned.

## Structure
- Package ram_arb_pkg: state enum (IDLE, WRITE, READ), grant-owner enum, ADR_SIZE helper function.
- One sub-module natural: ram_rr_arb2 — 2-way round-robin pick (inputs two reqs + lastGnt, outputs one-hot pick), purely combinational.

## Test plan
- Reset then wrReq, wrAdr=5, wrData=0xA7 → ramWr=1 with ramAdr=5, ramDataIn=0xA7 one cycle after request, wrGnt same cycle; RAM[5]=0xA7.
- Then rdReq, rdAdr=5 → ramRd=1 one cycle after request, rdData=0xA7 and rdValid=1 two cycles after request.
- wrReq and rdReq both held high from reset for 8 cycles → grants W,R,W,R; ramRd/ramWr never both 1.
- wrReq with wrAdr=784 (LENGTH_SIZE=784) → wrGnt=1, adrErr=1, ramWr=0; RAM unchanged. Same for rdAdr=800: rdGnt, adrErr, no rdValid.
- rst asserted during READ cycle → next cycle state IDLE, rdValid=0, all strobes 0; rdData retains 0 after reset.
- Write adr 783 then read adr 783 (top of range) → data returned correctly, no adrErr.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the image-buffer RAM arbiter: FSM states, grant owner,
// and the address-width helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_WRITE = 1'b0,
        OWNER_READ  = 1'b1
    } owner_t;

    // Address bits needed to cover a RAM of the given depth (at least one bit).
    function automatic int adr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin pick between the pixel writer and the CNN reader.
// pick is one-hot: bit 0 = writer, bit 1 = reader, 0 = nobody asked.
module ram_rr_arb2 (
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic       last_was_read,
    output logic [1:0] pick
);

    // On contention the side that did not win last time gets the slot.
    always_comb begin
        pick = 2'b00;
        if (wr_req && rd_req) begin
            pick = last_was_read ? 2'b01 : 2'b10;
        end else if (wr_req) begin
            pick = 2'b01;
        end else if (rd_req) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port image-buffer RAM between the stream pixel loader
// (writer) and the CNN engine (reader). One access every two cycles; every
// strobe is a register updated together with the state, so nothing on the
// outputs depends combinationally on the request inputs.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int WORD_SIZE   = 8,
    parameter  int LENGTH_SIZE = 784,
    localparam int ADR_SIZE    = adr_bits(LENGTH_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrReq,
    input  logic [ADR_SIZE-1:0]  wrAdr,
    input  logic [WORD_SIZE-1:0] wrData,
    output logic                 wrGnt,
    input  logic                 rdReq,
    input  logic [ADR_SIZE-1:0]  rdAdr,
    output logic                 rdGnt,
    output logic [WORD_SIZE-1:0] rdData,
    output logic                 rdValid,
    output logic                 adrErr,
    output logic                 ramRd,
    output logic                 ramWr,
    output logic [ADR_SIZE-1:0]  ramAdr,
    output logic [WORD_SIZE-1:0] ramDataIn,
    input  logic [WORD_SIZE-1:0] ramDataOut
);

    // One extra bit so a power-of-two depth does not wrap the limit to zero.
    localparam logic [ADR_SIZE:0] ADR_LIMIT = LENGTH_SIZE[ADR_SIZE:0];

    arb_state_t state;
    owner_t     last_gnt;
    logic [1:0] pick;
    logic       wr_in_range;
    logic       rd_in_range;

    ram_rr_arb2 u_pick (
        .wr_req        (wrReq),
        .rd_req        (rdReq),
        .last_was_read (last_gnt == OWNER_READ),
        .pick          (pick)
    );

    // Range check of the requested addresses, unsigned.
    always_comb begin
        wr_in_range = ({1'b0, wrAdr} < ADR_LIMIT);
        rd_in_range = ({1'b0, rdAdr} < ADR_LIMIT);
    end

    // Arbiter FSM: IDLE picks and latches, WRITE/READ last one cycle each.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= OWNER_READ;
            wrGnt     <= 1'b0;
            rdGnt     <= 1'b0;
            rdValid   <= 1'b0;
            adrErr    <= 1'b0;
            ramRd     <= 1'b0;
            ramWr     <= 1'b0;
            ramAdr    <= '0;
            ramDataIn <= '0;
            rdData    <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            wrGnt   <= 1'b0;
            rdGnt   <= 1'b0;
            rdValid <= 1'b0;
            adrErr  <= 1'b0;
            ramRd   <= 1'b0;
            ramWr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick[0]) begin
                        state     <= WRITE;
                        wrGnt     <= 1'b1;
                        ramAdr    <= wrAdr;
                        ramDataIn <= wrData;
                        if (wr_in_range) ramWr  <= 1'b1;
                        else             adrErr <= 1'b1;
                    end else if (pick[1]) begin
                        state  <= READ;
                        rdGnt  <= 1'b1;
                        ramAdr <= rdAdr;
                        if (rd_in_range) ramRd  <= 1'b1;
                        else             adrErr <= 1'b1;
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    last_gnt <= OWNER_WRITE;
                end
                READ: begin
                    state    <= IDLE;
                    last_gnt <= OWNER_READ;
                    // RAM output is only driven while ramRd is high.
                    if (ramRd) begin
                        rdData  <= ramDataOut;
                        rdValid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
